// File: rtl/entity_frame_latch.sv
// entity_frame_latch
// Double-buffered entity register file feeding the frame-buffer stage.
// Game logic stages entity words at any time; the staged bank is copied
// into the live bank once per frame, at the rising edge of the
// vertical-blanking match (V == VSTART, H == 0), so the live outputs
// never change mid-frame.

module entity_frame_latch #(
  parameter logic [9:0]  VSTART = 10'd480,
  parameter logic [13:0] EMPTY  = 14'h3C00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  counter_H,
  input  logic [9:0]  counter_V,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [3:0]  wr_slot,
  input  logic [13:0] wr_entity,
  input  logic        clear_req,
  output logic        wr_err,
  output logic [13:0] entity_1,
  output logic [13:0] entity_2,
  output logic [13:0] entity_3,
  output logic [13:0] entity_4,
  output logic [13:0] entity_5,
  output logic [13:0] entity_6,
  output logic [13:0] entity_7_Array,
  output logic [13:0] entity_8_Flip,
  output logic [13:0] entity_9_Flip,
  output logic        pending,
  output logic        frame_tick,
  output logic [7:0]  frame_count
);

  localparam int NSLOT = 9;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PENDING = 2'd1,
    S_COMMIT  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        dirty_q, dirty_d;
  logic        match, match_q, trig;
  logic        wr_acc, wr_good, wr_bad, clear_acc;
  logic        wr_err_q, frame_tick_q;
  logic [7:0]  frame_count_q, frame_count_d;
  logic [13:0] staging_q [NSLOT];
  logic [13:0] staging_d [NSLOT];
  logic [13:0] live_q    [NSLOT];
  logic [13:0] live_d    [NSLOT];

  // Commit point: one trigger per frame even if the counters stall on it.
  assign match = (counter_V == VSTART) && (counter_H == 10'd0);
  assign trig  = match && !match_q;

  // Writes and clears are refused only during the single copy cycle.
  assign wr_ready  = (state_q != S_COMMIT);
  assign wr_acc    = wr_valid && wr_ready;
  assign wr_good   = wr_acc && (wr_slot <= 4'd8);
  assign wr_bad    = wr_acc && (wr_slot > 4'd8);
  assign clear_acc = clear_req && (state_q != S_COMMIT);

  // Next state and dirty tracking; a write on the trigger edge still marks
  // the bank dirty so it joins the commit that follows.
  always_comb begin
    state_d = state_q;
    dirty_d = dirty_q;
    case (state_q)
      S_IDLE: begin
        if (trig)                        state_d = S_COMMIT;
        else if (wr_good || clear_acc)   state_d = S_PENDING;
      end
      S_PENDING: begin
        if (trig)                        state_d = S_COMMIT;
      end
      S_COMMIT: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (state_q == S_COMMIT) dirty_d = 1'b0;
    else                     dirty_d = dirty_q || wr_good || clear_acc;
  end

  // Staging update (clear first, then the write overrides its slot) and
  // live copy when a dirty bank reaches the commit cycle.
  always_comb begin
    for (int i = 0; i < NSLOT; i++) begin
      staging_d[i] = staging_q[i];
      live_d[i]    = live_q[i];
      if (clear_acc)                          staging_d[i] = EMPTY;
      if (wr_good && (wr_slot == 4'(i)))      staging_d[i] = wr_entity;
      if ((state_q == S_COMMIT) && dirty_q)   live_d[i]    = staging_q[i];
    end
  end

  assign frame_count_d = (state_q == S_COMMIT) ? frame_count_q + 8'd1 : frame_count_q;

  // Control state, edge detector and status pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      dirty_q       <= 1'b0;
      match_q       <= 1'b0;
      wr_err_q      <= 1'b0;
      frame_tick_q  <= 1'b0;
      frame_count_q <= 8'd0;
    end else begin
      state_q       <= state_d;
      dirty_q       <= dirty_d;
      match_q       <= match;
      wr_err_q      <= wr_bad;
      frame_tick_q  <= (state_q == S_COMMIT);
      frame_count_q <= frame_count_d;
    end
  end

  // Staging and live banks; reset clears both so an aborted commit leaves live empty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NSLOT; i++) begin
        staging_q[i] <= EMPTY;
        live_q[i]    <= EMPTY;
      end
    end else begin
      for (int i = 0; i < NSLOT; i++) begin
        staging_q[i] <= staging_d[i];
        live_q[i]    <= live_d[i];
      end
    end
  end

  assign wr_err         = wr_err_q;
  assign pending        = dirty_q;
  assign frame_tick     = frame_tick_q;
  assign frame_count    = frame_count_q;
  assign entity_1       = live_q[0];
  assign entity_2       = live_q[1];
  assign entity_3       = live_q[2];
  assign entity_4       = live_q[3];
  assign entity_5       = live_q[4];
  assign entity_6       = live_q[5];
  assign entity_7_Array = live_q[6];
  assign entity_8_Flip  = live_q[7];
  assign entity_9_Flip  = live_q[8];

endmodule

// File: tb/tb_entity_frame_latch.sv
// Scoreboard bench for entity_frame_latch: stimulus pushes the expected
// live bank per commit and expected error pulses; a negedge monitor pops
// and compares whenever frame_tick or wr_err is presented.

module tb_entity_frame_latch;

  localparam logic [13:0] EMPTY = 14'h3C00;

  typedef struct packed {
    logic [8:0][13:0] ent;
    logic [7:0]       fc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [9:0]  counter_H = 10'd0;
  logic [9:0]  counter_V = 10'd0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [3:0]  wr_slot = 4'd0;
  logic [13:0] wr_entity = 14'd0;
  logic        clear_req = 1'b0;
  logic        wr_err;
  logic [13:0] e1, e2, e3, e4, e5, e6, e7, e8, e9;
  logic        pending;
  logic        frame_tick;
  logic [7:0]  frame_count;

  logic [8:0][13:0] dut_ent;
  assign dut_ent = {e9, e8, e7, e6, e5, e4, e3, e2, e1};

  exp_t             commit_q [$];
  logic             err_q    [$];
  logic [8:0][13:0] exp_live;
  logic [7:0]       exp_fc;
  int               n_cmp = 0;
  int               n_bad = 0;

  entity_frame_latch dut (
    .clk(clk), .reset(reset), .counter_H(counter_H), .counter_V(counter_V),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_slot(wr_slot),
    .wr_entity(wr_entity), .clear_req(clear_req), .wr_err(wr_err),
    .entity_1(e1), .entity_2(e2), .entity_3(e3), .entity_4(e4),
    .entity_5(e5), .entity_6(e6), .entity_7_Array(e7),
    .entity_8_Flip(e8), .entity_9_Flip(e9),
    .pending(pending), .frame_tick(frame_tick), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_live(input string tag);
    for (int i = 0; i < 9; i++)
      check($sformatf("%s_ent%0d", tag, i + 1), 32'(dut_ent[i]), 32'(exp_live[i]));
  endtask

  task automatic push_commit();
    exp_t r;
    exp_fc = exp_fc + 8'd1;
    r.ent = exp_live;
    r.fc  = exp_fc;
    commit_q.push_back(r);
  endtask

  task automatic write(input logic [3:0] slot, input logic [13:0] val);
    wr_valid  = 1'b1;
    wr_slot   = slot;
    wr_entity = val;
    tick();
    wr_valid  = 1'b0;
  endtask

  task automatic commit_frame();
    counter_V = 10'd480; counter_H = 10'd0;
    tick();
    counter_V = 10'd0;   counter_H = 10'd1;
    tick(); tick(); tick();
  endtask

  // Monitor: compare whenever the DUT presents a commit tick or an error pulse.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (frame_tick) begin
          if (commit_q.size() == 0) begin
            check("unexpected_frame_tick", 32'd1, 32'd0);
          end else begin
            exp_t r;
            r = commit_q.pop_front();
            for (int i = 0; i < 9; i++)
              check($sformatf("commit_ent%0d", i + 1), 32'(dut_ent[i]), 32'(r.ent[i]));
            check("commit_frame_count", 32'(frame_count), 32'(r.fc));
            check("commit_pending", 32'(pending), 32'd0);
          end
        end
        if (wr_err) begin
          if (err_q.size() == 0) begin
            check("unexpected_wr_err", 32'd1, 32'd0);
          end else begin
            logic ep;
            ep = err_q.pop_front();
            check("wr_err_pending", 32'(pending), 32'(ep));
          end
        end
      end
    end
  end

  logic [13:0] load_vals [9];
  logic [7:0]  fc_before;

  initial begin
    load_vals = '{14'h0101, 14'h0202, 14'h0303, 14'h0404, 14'h0505,
                  14'h0606, 14'h0707, 14'h0808, 14'h0909};
    for (int i = 0; i < 9; i++) exp_live[i] = EMPTY;
    exp_fc = 8'd0;

    // Reset state
    tick(); tick();
    check_all_live("rst");
    check("rst_frame_count", 32'(frame_count), 32'd0);
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_wr_ready", 32'(wr_ready), 32'd1);
    check("rst_frame_tick", 32'(frame_tick), 32'd0);
    check("rst_wr_err", 32'(wr_err), 32'd0);
    reset = 1'b0;
    counter_V = 10'd100; counter_H = 10'd0;
    tick();

    // Basic commit: slot 2 staged, invisible until the commit point
    write(4'd2, 14'h0512);
    check("basic_pending", 32'(pending), 32'd1);
    check("basic_ent3_before", 32'(e3), 32'(EMPTY));
    tick();
    check("basic_ent3_still", 32'(e3), 32'(EMPTY));
    exp_live[2] = 14'h0512;
    push_commit();
    commit_frame();

    // Held counters: one commit over 5 held clocks; write during COMMIT waits
    push_commit();
    counter_V = 10'd480; counter_H = 10'd0;
    tick();                                   // E0 -> COMMIT
    wr_valid = 1'b1; wr_slot = 4'd8; wr_entity = 14'h2A7F;
    check("held_wr_ready_commit", 32'(wr_ready), 32'd0);
    tick();                                   // E1: refused, copy happens
    check("held_wr_ready_after", 32'(wr_ready), 32'd1);
    tick();                                   // E2: accepted
    wr_valid = 1'b0;
    tick(); tick();                           // E3, E4 still held
    counter_V = 10'd0; counter_H = 10'd1;
    tick(); tick();
    check("held_pending", 32'(pending), 32'd1);
    check("held_ent9_not_yet", 32'(e9), 32'(EMPTY));
    exp_live[8] = 14'h2A7F;
    push_commit();
    commit_frame();

    // Write on the trigger edge joins this commit
    counter_V = 10'd100; counter_H = 10'd3;
    tick();
    exp_live[0] = 14'h1001;
    push_commit();
    counter_V = 10'd480; counter_H = 10'd0;
    wr_valid = 1'b1; wr_slot = 4'd0; wr_entity = 14'h1001;
    tick();
    wr_valid = 1'b0;
    counter_V = 10'd0; counter_H = 10'd1;
    tick(); tick(); tick();

    // Invalid slot: error pulse, nothing staged
    err_q.push_back(1'b0);
    write(4'd9, 14'h3FFF);
    tick();
    check("bad_pending", 32'(pending), 32'd0);
    check("bad_wr_ready", 32'(wr_ready), 32'd1);
    push_commit();
    commit_frame();

    // Load all slots, then clear with a simultaneous write of slot 4
    for (int i = 0; i < 9; i++) write(4'(i), load_vals[i]);
    clear_req = 1'b1;
    wr_valid = 1'b1; wr_slot = 4'd4; wr_entity = 14'h0C33;
    tick();
    clear_req = 1'b0; wr_valid = 1'b0;
    for (int i = 0; i < 9; i++) exp_live[i] = EMPTY;
    exp_live[4] = 14'h0C33;
    push_commit();
    commit_frame();

    // 256 idle frames: outputs steady, frame_count wraps back
    fc_before = exp_fc;
    for (int f = 0; f < 256; f++) begin
      push_commit();
      commit_frame();
    end
    check("wrap_frame_count", 32'(frame_count), 32'(fc_before));
    check_all_live("wrap");

    // Reset during COMMIT aborts the copy
    write(4'd3, 14'h0777);
    counter_V = 10'd480; counter_H = 10'd0;
    tick();                                   // E0 -> COMMIT
    reset = 1'b1;
    #2;
    for (int i = 0; i < 9; i++) exp_live[i] = EMPTY;
    exp_fc = 8'd0;
    check_all_live("abort");
    check("abort_frame_count", 32'(frame_count), 32'd0);
    check("abort_pending", 32'(pending), 32'd0);
    check("abort_wr_ready", 32'(wr_ready), 32'd1);
    counter_V = 10'd0; counter_H = 10'd1;
    tick();
    reset = 1'b0;
    tick(); tick(); tick();
    check("abort_ent4_after", 32'(e4), 32'(EMPTY));

    // Normal operation resumes after reset
    write(4'd6, 14'h0ABC);
    exp_live[6] = 14'h0ABC;
    push_commit();
    commit_frame();

    for (int k = 0; k < 20 && (commit_q.size() != 0 || err_q.size() != 0); k++) tick();
    check("commit_queue_drained", 32'(commit_q.size()), 32'd0);
    check("err_queue_drained", 32'(err_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
